// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, rounding and narrowing helpers for the butterfly PE; narrowing saturates when PE_SAT_EN is defined, else wraps
package pe_pkg;

    localparam int MAX_W        = 64;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_TF_WIDTH = 16;
    localparam int DEF_FRAC     = 14;
    localparam int SUM_W        = DEF_WIDTH + 1;
    localparam int PROD_W       = SUM_W + DEF_TF_WIDTH + 1;

`ifdef PE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef logic signed [MAX_W-1:0] wide_t;

    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

    function automatic int prod_w(input int w, input int tw);
        return sum_w(w) + tw + 1;
    endfunction

    function automatic wide_t rnd_half(input int k);
        return k > 0 ? wide_t'(64'sd1 <<< (k - 1)) : wide_t'(0);
    endfunction

    function automatic wide_t round_hu(input wide_t x, input int k);
        return (x + rnd_half(k)) >>> k;
    endfunction

    function automatic wide_t narrow(input wide_t x, input int w);
`ifdef PE_SAT_EN
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = ~hi;
        return x > hi ? hi : x < lo ? lo : x;
`else
        return (x <<< (MAX_W - w)) >>> (MAX_W - w);
`endif
    endfunction

    // Only meaningful with saturation; folds to constant 0 in the wrapping build.
    function automatic logic clamped(input wide_t x, input int w);
        return SAT_EN && (narrow(x, w) != x);
    endfunction

endpackage

// File: rtl/pe_cmul.sv
// pe_cmul: two-stage full-precision rotation of a real difference pair by a twiddle
module pe_cmul
    import pe_pkg::*;
#(
    parameter int SW = SUM_W,
    parameter int TW = DEF_TF_WIDTH,
    parameter int PW = SW + TW + 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic signed [SW-1:0] d0,
    input  logic signed [SW-1:0] d1,
    input  logic signed [TW-1:0] tr,
    input  logic signed [TW-1:0] ti,
    output logic                 out_valid,
    output logic signed [PW-1:0] pr,
    output logic signed [PW-1:0] pi
);

    localparam int MW = SW + TW;

    logic                 v1;
    logic signed [MW-1:0] p_rr, p_ii, p_ri, p_ir;

    // valid bits for the product and combine stages
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            out_valid <= v1;
        end
    end

    // partial products, then combine into the rotated pair
    always_ff @(posedge Clk) begin
        if (en) begin
            p_rr <= MW'(d0) * MW'(tr);
            p_ii <= MW'(d1) * MW'(ti);
            p_ri <= MW'(d0) * MW'(ti);
            p_ir <= MW'(d1) * MW'(tr);
            pr   <= PW'(p_rr) - PW'(p_ii);
            pi   <= -(PW'(p_ri) + PW'(p_ir));
        end
    end

endmodule

// File: rtl/pe_pipe.sv
// pe_pipe: flow-controlled radix-2 butterfly PE with twiddle rotation, optional /2 scaling, round-half-up; saturates when PE_SAT_EN is defined
module pe_pipe
    import pe_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TF_WIDTH = DEF_TF_WIDTH,
    parameter int FRAC     = DEF_FRAC
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic signed [WIDTH-1:0] in0,
    input  logic signed [WIDTH-1:0] in1,
    input  logic signed [WIDTH-1:0] in2,
    input  logic signed [WIDTH-1:0] in3,
    input  logic [2*TF_WIDTH-1:0]   tf,
    input  logic                    bypass_n,
    input  logic                    scale,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out0,
    output logic signed [WIDTH-1:0] out1,
    output logic signed [WIDTH-1:0] out2,
    output logic signed [WIDTH-1:0] out3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    ovf
);

    localparam int SW = sum_w(WIDTH);
    localparam int PW = prod_w(WIDTH, TF_WIDTH);

    logic                    adv;
    logic                    v0, v2;
    logic signed [SW-1:0]    s0_0, s1_0, d0_0, d1_0;
    logic signed [SW-1:0]    s0_1, s1_1, d0_1, d1_1;
    logic signed [SW-1:0]    s0_2, s1_2, d0_2, d1_2;
    logic signed [TF_WIDTH-1:0] tr_0, ti_0;
    logic                    byp_0, byp_1, byp_2;
    logic                    sc_0, sc_1, sc_2;
    logic signed [PW-1:0]    pr_2, pi_2;
    int                      k0, k2;
    wide_t                   r0, r1, r2, r3;

    // whole pipe advances together unless the output is held by downstream
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    // S0 valid bit
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            v0 <= 1'b0;
        else if (adv)
            v0 <= in_valid;
    end

    // S0 butterfly and per-sample controls; S1/S2 carry sums, differences and flags alongside the multiplier
    always_ff @(posedge Clk) begin
        if (adv) begin
            s0_0  <= SW'(in0) + SW'(in1);
            s1_0  <= SW'(in2) + SW'(in3);
            d0_0  <= SW'(in0) - SW'(in1);
            d1_0  <= SW'(in2) - SW'(in3);
            tr_0  <= tf[2*TF_WIDTH-1:TF_WIDTH];
            ti_0  <= tf[TF_WIDTH-1:0];
            byp_0 <= bypass_n;
            sc_0  <= scale;
            s0_1  <= s0_0;
            s1_1  <= s1_0;
            d0_1  <= d0_0;
            d1_1  <= d1_0;
            byp_1 <= byp_0;
            sc_1  <= sc_0;
            s0_2  <= s0_1;
            s1_2  <= s1_1;
            d0_2  <= d0_1;
            d1_2  <= d1_1;
            byp_2 <= byp_1;
            sc_2  <= sc_1;
        end
    end

    pe_cmul #(
        .SW (SW),
        .TW (TF_WIDTH),
        .PW (PW)
    ) u_cmul (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .en        (adv),
        .in_valid  (v0),
        .d0        (d0_0),
        .d1        (d1_0),
        .tr        (tr_0),
        .ti        (ti_0),
        .out_valid (v2),
        .pr        (pr_2),
        .pi        (pi_2)
    );

    // round each result; rotated outputs also drop the twiddle fraction bits
    always_comb begin
        k0 = int'(sc_2);
        k2 = byp_2 ? FRAC + k0 : k0;
        r0 = round_hu(wide_t'(s0_2), k0);
        r1 = round_hu(wide_t'(s1_2), k0);
        r2 = byp_2 ? round_hu(wide_t'(pr_2), k2) : round_hu(wide_t'(d0_2), k0);
        r3 = byp_2 ? round_hu(wide_t'(pi_2), k2) : round_hu(wide_t'(d1_2), k0);
    end

    // S3 narrow into the output register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            out0      <= WIDTH'(narrow(r0, WIDTH));
            out1      <= WIDTH'(narrow(r1, WIDTH));
            out2      <= WIDTH'(narrow(r2, WIDTH));
            out3      <= WIDTH'(narrow(r3, WIDTH));
            ovf       <= clamped(r0, WIDTH) || clamped(r1, WIDTH) || clamped(r2, WIDTH) || clamped(r3, WIDTH);
        end
    end

endmodule

// File: tb/tb_pe_pipe.sv
// tb_pe_pipe: scoreboard bench for pe_pipe (WIDTH=16, TF_WIDTH=16, FRAC=14)
module tb_pe_pipe;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic signed [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [31:0]        tf = '0;
    logic               bypass_n = 1'b0, scale = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic               in_ready, out_valid, ovf;
    logic [15:0]        out0, out1, out2, out3;

    typedef struct packed {
        logic [63:0] o;
        logic        ovf;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    logic        stalled = 1'b0;
    logic [63:0] prev_o = '0;
    logic        prev_ovf = 1'b0;
    logic        done_rand = 1'b0;

    localparam logic [31:0] TF_ONE  = {16'sd16384, 16'sd0};
    localparam logic [31:0] TF_MJ   = {16'sd0, -16'sd16384};

    always #5 Clk = ~Clk;

    pe_pipe dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .tf        (tf),
        .bypass_n  (bypass_n),
        .scale     (scale),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint rnd(input longint x, input int k);
        return k > 0 ? (x + (longint'(1) <<< (k - 1))) >>> k : x;
    endfunction

    function automatic exp_t model(input logic signed [15:0] a, b, c, d, input logic [31:0] t, input logic byp, sc);
        longint x0, x1, x2, x3, tr, ti, s0, s1, d0, d1;
        longint r[4];
        exp_t   e;
        int     k;
        x0 = a; x1 = b; x2 = c; x3 = d;
        tr = longint'($signed(t[31:16]));
        ti = longint'($signed(t[15:0]));
        s0 = x0 + x1; s1 = x2 + x3; d0 = x0 - x1; d1 = x2 - x3;
        k = sc ? 1 : 0;
        r[0] = rnd(s0, k);
        r[1] = rnd(s1, k);
        r[2] = byp ? rnd(d0 * tr - d1 * ti, 14 + k) : rnd(d0, k);
        r[3] = byp ? rnd(-(d0 * ti + d1 * tr), 14 + k) : rnd(d1, k);
        e.ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef PE_SAT_EN
            if (r[i] > 32767) begin r[i] = 32767; e.ovf = 1'b1; end
            else if (r[i] < -32768) begin r[i] = -32768; e.ovf = 1'b1; end
`endif
            e.o[16*i +: 16] = r[i][15:0];
        end
        return e;
    endfunction

    // scoreboard: push on accept, pop and compare on delivery, watch stall behaviour
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset_n) begin
            sbq.delete();
            stalled = 1'b0;
        end else begin
            if (in_valid && in_ready)
                sbq.push_back(model(in0, in1, in2, in3, tf, bypass_n, scale));
            if (stalled) begin
                chk("stall_hold", {out3, out2, out1, out0}, prev_o);
                chk("stall_ovf", 64'(ovf), 64'(prev_ovf));
                chk("stall_valid", 64'(out_valid), 64'(1));
            end
            if (out_valid && !out_ready)
                chk("in_ready_stall", 64'(in_ready), 64'(0));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0)
                    chk("unexpected_out", 64'(out_valid), 64'(0));
                else begin
                    e = sbq.pop_front();
                    chk("out0", 64'(out0), 64'(e.o[15:0]));
                    chk("out1", 64'(out1), 64'(e.o[31:16]));
                    chk("out2", 64'(out2), 64'(e.o[47:32]));
                    chk("out3", 64'(out3), 64'(e.o[63:48]));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
                end
            end
            stalled  = out_valid && !out_ready;
            prev_o   = {out3, out2, out1, out0};
            prev_ovf = ovf;
        end
    end

    task automatic send(input logic signed [15:0] a, b, c, d, input logic [31:0] t, input logic byp, sc);
        int   n;
        logic ok;
        n = 0;
        in0 = a; in1 = b; in2 = c; in3 = d;
        tf = t; bypass_n = byp; scale = sc; in_valid = 1'b1;
        do begin
            @(negedge Clk);
            ok = in_ready;
            @(posedge Clk);
            #1;
            n++;
        end while (!ok && n < 50);
        chk("send_accept", 64'(ok), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic latency(input string tag);
        int c;
        c = 0;
        do begin
            @(negedge Clk);
            c++;
        end while (!out_valid && c < 20);
        chk(tag, 64'(c), 64'(4));
    endtask

    task automatic drain(input string tag);
        repeat (10) @(posedge Clk);
        #1;
        chk(tag, 64'(sbq.size()), 64'(0));
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge Clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_outs"}, {out3, out2, out1, out0}, 64'(0));
        chk({tag, "_ovf"}, 64'(ovf), 64'(0));
        chk({tag, "_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        check_reset_state("reset");

        @(posedge Clk); #1;
        send(16'sd100, 16'sd20, 16'sd50, 16'sd10, TF_ONE, 1'b1, 1'b0);
        latency("latency_first");
        @(posedge Clk); #1;
        send(16'sd100, 16'sd20, 16'sd50, 16'sd10, TF_MJ, 1'b1, 1'b0);
        send(16'sd32767, 16'sd32767, 16'sd0, 16'sd0, TF_ONE, 1'b1, 1'b0);
        send(16'sd32767, 16'sd32767, 16'sd0, 16'sd0, TF_ONE, 1'b1, 1'b1);
        send(-16'sd32768, 16'sd32767, -16'sd32768, -16'sd32768, TF_MJ, 1'b1, 1'b0);
        send(16'sd3, 16'sd0, 16'sd0, 16'sd0, TF_ONE, 1'b0, 1'b1);
        send(-16'sd3, 16'sd0, 16'sd0, 16'sd0, TF_ONE, 1'b0, 1'b1);
        drain("drain_directed");

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(16'(i * 1000 + 7), 16'(-i * 300), 16'(i * 50), 16'(11 * i), TF_MJ, 1'b1, 1'(i % 2));
            end
            begin
                repeat (4) @(posedge Clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge Clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        send(16'sd1, 16'sd2, 16'sd3, 16'sd4, TF_ONE, 1'b1, 1'b0);
        send(16'sd5, 16'sd6, 16'sd7, 16'sd8, TF_ONE, 1'b1, 1'b0);
        send(16'sd9, 16'sd10, 16'sd11, 16'sd12, TF_ONE, 1'b1, 1'b0);
        Reset_n = 1'b0;
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        check_reset_state("midreset");
        repeat (8) @(posedge Clk);
        #1;
        send(16'sd200, -16'sd40, 16'sd7, 16'sd9, TF_MJ, 1'b1, 1'b1);
        latency("latency_after_reset");
        drain("drain_reset");

        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom, 1'($urandom), 1'($urandom));
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    @(posedge Clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
